// File: rtl/spectrum_peak_store.sv
// Per-bin spectrum store with frame peak search for the display path.
// Define SPECTRUM_PEAK_HOLD_EN for decaying peak-hold instead of plain overwrite.
module spectrum_peak_store #(
    parameter logic [7:0] DECAY_STEP = 8'd1,
    parameter bit         SKIP_DC    = 1'b1
) (
    input  logic       ckFreq,
    input  logic       aresetn,
    input  logic       flgFreqSampleValid,
    input  logic [9:0] addrFreq,
    input  logic [7:0] byteFreqSample,
    input  logic [8:0] rdAddr,
    output logic [7:0] rdData,
    output logic [8:0] peakBin,
    output logic [7:0] peakVal,
    output logic       flgFrameDone,
    output logic       flgBusy
);

    typedef enum logic [1:0] {
        CLEAR,
        WAIT_SOF,
        CAPTURE,
        SKIP_HI
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [8:0] clrPtr;
    logic [7:0] mem [512];

    logic       wrPend;
    logic [8:0] wrAddr;
    logic [7:0] wrByte;
    logic [7:0] newVal;

    logic [8:0] trkBin;
    logic [7:0] trkVal;
    logic [8:0] trkBinNext;
    logic [7:0] trkValNext;
    logic       candOk;

    logic isSof;
    logic isEof;
    logic isLow;
    logic accept;
    logic restart;
    logic frameEnd;

    assign isSof = flgFreqSampleValid && (addrFreq == 10'd0);
    assign isEof = flgFreqSampleValid && (addrFreq == 10'd1023);
    assign isLow = flgFreqSampleValid && !addrFreq[9];

    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            state  <= CLEAR;
            clrPtr <= 9'd0;
        end else begin
            state <= stateNext;
            if (flgBusy) begin
                clrPtr <= clrPtr + 9'd1;
            end
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            CLEAR: begin
                if (clrPtr == 9'd511) stateNext = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (isSof) stateNext = CAPTURE;
            end
            CAPTURE: begin
                if (isLow && addrFreq[8:0] == 9'd511) stateNext = SKIP_HI;
            end
            SKIP_HI: begin
                if (isSof) stateNext = CAPTURE;
                else if (isEof) stateNext = WAIT_SOF;
            end
            default: stateNext = CLEAR;
        endcase
    end

    always_comb begin
        flgBusy  = 1'b0;
        accept   = 1'b0;
        restart  = 1'b0;
        frameEnd = 1'b0;
        unique case (state)
            CLEAR: flgBusy = 1'b1;
            WAIT_SOF: begin
                accept  = isSof;
                restart = isSof;
            end
            CAPTURE: begin
                accept  = isLow;
                restart = isSof;
            end
            SKIP_HI: begin
                accept   = isSof;
                restart  = isSof;
                frameEnd = isEof && !isSof;
            end
            default: flgBusy = 1'b1;
        endcase
    end

    // Accepted sample is written one cycle later; bins are distinct so no hazard.
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            wrPend <= 1'b0;
            wrAddr <= 9'd0;
            wrByte <= 8'd0;
        end else begin
            wrPend <= accept;
            if (accept) begin
                wrAddr <= addrFreq[8:0];
                wrByte <= byteFreqSample;
            end
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    logic [7:0] oldVal;
    logic [7:0] decayed;

    assign oldVal  = mem[wrAddr];
    assign decayed = (oldVal > DECAY_STEP) ? oldVal - DECAY_STEP : 8'd0;
    assign newVal  = (wrByte > decayed) ? wrByte : decayed;
`else
    assign newVal = wrByte;
`endif

    always_ff @(posedge ckFreq) begin
        if (flgBusy) begin
            mem[clrPtr] <= 8'd0;
        end else if (wrPend) begin
            mem[wrAddr] <= newVal;
        end
    end

    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            rdData <= 8'd0;
        end else begin
            rdData <= flgBusy ? 8'd0 : mem[rdAddr];
        end
    end

    assign candOk = wrPend && !(SKIP_DC && wrAddr == 9'd0) &&
                    (newVal > trkVal);
    assign trkBinNext = candOk ? wrAddr : trkBin;
    assign trkValNext = candOk ? newVal : trkVal;

    // A frame restart discards any compare still in flight.
    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            trkBin <= 9'd0;
            trkVal <= 8'd0;
        end else if (restart) begin
            trkBin <= {8'd0, SKIP_DC};
            trkVal <= 8'd0;
        end else begin
            trkBin <= trkBinNext;
            trkVal <= trkValNext;
        end
    end

    always_ff @(posedge ckFreq or negedge aresetn) begin
        if (!aresetn) begin
            peakBin      <= 9'd0;
            peakVal      <= 8'd0;
            flgFrameDone <= 1'b0;
        end else begin
            flgFrameDone <= frameEnd;
            if (frameEnd) begin
                peakBin <= trkBinNext;
                peakVal <= trkValNext;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_store.sv
// Directed bench for spectrum_peak_store: clear, frames, restart, reset.
// Expectations follow SPECTRUM_PEAK_HOLD_EN when the build defines it.
module tb_spectrum_peak_store;

    logic       ckFreq = 1'b0;
    logic       aresetn = 1'b0;
    logic       flgFreqSampleValid = 1'b0;
    logic [9:0] addrFreq = 10'd0;
    logic [7:0] byteFreqSample = 8'd0;
    logic [8:0] rdAddr = 9'd0;
    logic [7:0] rdData;
    logic [8:0] peakBin;
    logic [7:0] peakVal;
    logic       flgFrameDone;
    logic       flgBusy;

    int testCnt = 0;
    int failCnt = 0;
    int doneCnt = 0;
    int busyCnt = 0;
    logic [7:0] vals [1024];

    always #5 ckFreq = ~ckFreq;

    spectrum_peak_store dut (
        .ckFreq             (ckFreq),
        .aresetn            (aresetn),
        .flgFreqSampleValid (flgFreqSampleValid),
        .addrFreq           (addrFreq),
        .byteFreqSample     (byteFreqSample),
        .rdAddr             (rdAddr),
        .rdData             (rdData),
        .peakBin            (peakBin),
        .peakVal            (peakVal),
        .flgFrameDone       (flgFrameDone),
        .flgBusy            (flgBusy)
    );

    task automatic tick();
        @(posedge ckFreq);
        #1;
        if (flgFrameDone === 1'b1) doneCnt++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkRd(input string tag, input int a, input int exp);
        rdAddr = 9'(a);
        tick();
        check(tag, 32'(rdData), 32'(exp));
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 1024; i++) vals[i] = v;
    endtask

    task automatic fillA();
        fill(8'd10);
        vals[100] = 8'd200;
        vals[7]   = 8'd0;
    endtask

    // Stall cycles drive a bogus bin-0 sample that must be ignored.
    task automatic sendBins(input int lo, input int hi, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            flgFreqSampleValid = 1'b1;
            addrFreq = 10'(i);
            byteFreqSample = vals[i];
            tick();
            if (gaps) begin
                flgFreqSampleValid = 1'b0;
                addrFreq = 10'd0;
                byteFreqSample = 8'hFF;
                tick();
            end
        end
        flgFreqSampleValid = 1'b0;
        addrFreq = 10'd0;
        byteFreqSample = 8'd0;
    endtask

    task automatic waitClear(input string tag);
        busyCnt = 0;
        while (flgBusy === 1'b1 && busyCnt < 1000) begin
            busyCnt++;
            tick();
            if (busyCnt == 300) check({tag, "Rd"}, 32'(rdData), 32'd0);
        end
        check({tag, "Cycles"}, 32'(busyCnt), 32'd512);
    endtask

    initial begin
        rdAddr = 9'd255;
        tick();
        tick();
        check("rstRdData", 32'(rdData), 32'd0);
        check("rstPeakBin", 32'(peakBin), 32'd0);
        check("rstPeakVal", 32'(peakVal), 32'd0);
        check("rstDone", 32'(flgFrameDone), 32'd0);
        check("rstBusy", 32'(flgBusy), 32'd1);

        aresetn = 1'b1;
        waitClear("clr");
        checkRd("clrRd0", 0, 0);
        checkRd("clrRd255", 255, 0);
        checkRd("clrRd511", 511, 0);

        doneCnt = 0;
        fillA();
        sendBins(0, 1023, 1'b0);
        check("aDonePulse", 32'(flgFrameDone), 32'd1);
        check("aPeakBin", 32'(peakBin), 32'd100);
        check("aPeakVal", 32'(peakVal), 32'd200);
        tick();
        tick();
        check("aDoneCnt", 32'(doneCnt), 32'd1);
        checkRd("aRd100", 100, 200);
        checkRd("aRd5", 5, 10);

        doneCnt = 0;
        fill(8'd0);
        sendBins(0, 1023, 1'b0);
        tick();
        check("bDoneCnt", 32'(doneCnt), 32'd1);
`ifdef SPECTRUM_PEAK_HOLD_EN
        check("bPeakBin", 32'(peakBin), 32'd100);
        check("bPeakVal", 32'(peakVal), 32'd199);
        checkRd("bRd100", 100, 199);
        checkRd("bRd5", 5, 9);
`else
        check("bPeakBin", 32'(peakBin), 32'd1);
        check("bPeakVal", 32'(peakVal), 32'd0);
        checkRd("bRd100", 100, 0);
        checkRd("bRd5", 5, 0);
`endif
        checkRd("bRd7", 7, 0);

        doneCnt = 0;
        fillA();
        sendBins(0, 1023, 1'b1);
        tick();
        check("cDoneCnt", 32'(doneCnt), 32'd1);
        check("cPeakBin", 32'(peakBin), 32'd100);
        check("cPeakVal", 32'(peakVal), 32'd200);
        checkRd("cRd100", 100, 200);
        checkRd("cRd5", 5, 10);

        doneCnt = 0;
        fillA();
        vals[300] = 8'd250;
        sendBins(0, 600, 1'b0);
        tick();
        check("eNoDone", 32'(doneCnt), 32'd0);
        fillA();
        sendBins(0, 1023, 1'b0);
        tick();
        check("eDoneCnt", 32'(doneCnt), 32'd1);
`ifdef SPECTRUM_PEAK_HOLD_EN
        check("ePeakBin", 32'(peakBin), 32'd300);
        check("ePeakVal", 32'(peakVal), 32'd249);
        checkRd("eRd300", 300, 249);
`else
        check("ePeakBin", 32'(peakBin), 32'd100);
        check("ePeakVal", 32'(peakVal), 32'd200);
        checkRd("eRd300", 300, 10);
`endif
        checkRd("eRd100", 100, 200);

        doneCnt = 0;
        fillA();
        sendBins(0, 300, 1'b0);
        aresetn = 1'b0;
        #1;
        check("midRstRdData", 32'(rdData), 32'd0);
        check("midRstPeakBin", 32'(peakBin), 32'd0);
        check("midRstPeakVal", 32'(peakVal), 32'd0);
        check("midRstDone", 32'(flgFrameDone), 32'd0);
        check("midRstBusy", 32'(flgBusy), 32'd1);
        tick();
        tick();
        aresetn = 1'b1;
        waitClear("reclr");
        check("midRstDoneCnt", 32'(doneCnt), 32'd0);
        checkRd("reclrRd100", 100, 0);

        doneCnt = 0;
        fill(8'd0);
        vals[40]  = 8'd150;
        vals[300] = 8'd150;
        vals[0]   = 8'd255;
        sendBins(0, 1023, 1'b0);
        tick();
        check("dDoneCnt", 32'(doneCnt), 32'd1);
        check("dPeakBin", 32'(peakBin), 32'd40);
        check("dPeakVal", 32'(peakVal), 32'd150);
        checkRd("dRd0", 0, 255);
        checkRd("dRd300", 300, 150);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_store.md
SPECTRUM_PEAK_STORE -- requirements
Module: spectrum_peak_store

Interface
REQ-001 Parameter DECAY_STEP, default 8'd1: amount subtracted from a held bin value per frame.
REQ-002 Parameter SKIP_DC, default 1: when 1, bin 0 is excluded from peak search.
REQ-003 ckFreq  input  1  single clock; all logic rising-edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 flgFreqSampleValid  input  1  frequency sample qualifier from FFT stage.
REQ-006 addrFreq  input  10  bin index of current sample, 0..1023.
REQ-007 byteFreqSample  input  8  scaled bin power.
REQ-008 rdAddr  input  9  display read address, bins 0..511.
REQ-009 rdData  output  8  stored value at rdAddr.
REQ-010 peakBin  output  9  bin of largest value in last completed frame.
REQ-011 peakVal  output  8  value at peakBin.
REQ-012 flgFrameDone  output  1  one-cycle pulse on frame completion.
REQ-013 flgBusy  output  1  high while storage clear in progress.

Function
REQ-014 Storage SHALL hold 512 x 8 bits, one entry per bin 0..511; bins 512..1023 SHALL be ignored.
REQ-015 FSM states CLEAR, WAIT_SOF, CAPTURE, SKIP_HI; CLEAR entered on reset.
REQ-016 CLEAR: writes 0 to entries 0..511, one per cycle, 512 cycles, flgBusy=1, inputs ignored; then WAIT_SOF.
REQ-017 WAIT_SOF -> CAPTURE on valid sample with addrFreq==0; that sample is processed.
REQ-018 CAPTURE: each valid sample with addrFreq<512 updates entry addrFreq; after addrFreq==511 processed -> SKIP_HI.
REQ-019 SKIP_HI: valid sample with addrFreq==1023 -> flgFrameDone pulse next cycle, peakBin/peakVal updated same cycle, -> WAIT_SOF.
REQ-020 Valid sample with addrFreq==0 while in CAPTURE or SKIP_HI SHALL restart the frame: peak tracker reset, no flgFrameDone, sample processed as bin 0.
REQ-021 Deasserted flgFreqSampleValid SHALL stall; no state, entry or tracker change.
REQ-022 Update rule: new = max(byteFreqSample, sat(old - DECAY_STEP)), subtraction floors at 0, no wrap.
REQ-023 Entry write committed 1 cycle after accepted sample; successive bins never collide.
REQ-024 Peak tracker: strict greater-than compare on written value, lowest bin wins ties; bin 0 excluded when SKIP_DC=1; all-zero frame gives peakBin=SKIP_DC, peakVal=0.
REQ-025 rdData registered, 1-cycle latency from rdAddr; read of entry written same cycle returns old value.
REQ-026 rdData SHALL read 0 during CLEAR.

Reset
REQ-027 aresetn low: state=CLEAR, clear pointer=0, rdData=0, peakBin=0, peakVal=0, flgFrameDone=0, flgBusy=1, tracker=0.
REQ-028 Reset mid-frame abandons frame; no flgFrameDone; full CLEAR repeated.

Configuration
REQ-029 Macro SPECTRUM_PEAK_HOLD_EN defined: update rule per REQ-022.
REQ-030 Macro undefined: new = byteFreqSample (plain overwrite), DECAY_STEP unused, no read-modify-write path; all else identical.

Verification
REQ-031 Reset released -> flgBusy high exactly 512 cycles; rdData=0 for rdAddr 0, 255, 511.
REQ-032 Frame 0..1023 valid every cycle, bin 100=200, others 10 -> flgFrameDone once, peakBin=100, peakVal=200, rdAddr=100 gives 200.
REQ-033 Hold enabled, second frame all zero, DECAY_STEP=1 -> entry 100=199, entry 5=9; entry with 0 stays 0.
REQ-034 Bins 40 and 300 both 150 -> peakBin=40; bin 0=255 with SKIP_DC=1 -> peakBin ignores bin 0.
REQ-035 Valid toggled 1-0-1 across frame -> same results as REQ-032; addrFreq=0 injected at bin 600 -> no flgFrameDone, restart.
REQ-036 aresetn low at bin 300 -> no flgFrameDone, outputs per REQ-027, CLEAR reruns 512 cycles.
